// File: rtl/cpu_ctrl_fsm_if.sv
// Control bus between the multi-cycle controller and the datapath/memory side.
// The master modport is the controller; the slave modport is the datapath/memory.
interface cpu_ctrl_fsm_if #(
   parameter int RETIRE_W = 16
);
   logic                start;
   logic [3:0]          opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                ir_write;
   logic                mem_read;
   logic                mem_write;
   logic [2:0]          alu_op;
   logic                memtoreg_sel;
   logic                reg_write;
   logic                halted;
   logic                illegal;
   logic [RETIRE_W-1:0] retired;

   modport master (
      input  start, opcode, mem_ready,
      output pc_write, ir_write, mem_read, mem_write, alu_op,
             memtoreg_sel, reg_write, halted, illegal, retired
   );

   modport slave (
      output start, opcode, mem_ready,
      input  pc_write, ir_write, mem_read, mem_write, alu_op,
             memtoreg_sel, reg_write, halted, illegal, retired
   );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing for the 8-bit datapath,
// with memory handshake, sticky illegal-opcode flag and a retired-instruction counter.
module cpu_ctrl_fsm #(
   parameter int RETIRE_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   cpu_ctrl_fsm_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [2:0] alu_op;
      logic       memtoreg_sel;
      logic       reg_write;
      logic       halted;
   } ctrl_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_LOAD  = 4'h5;
   localparam logic [3:0] OP_STORE = 4'h6;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_PASS = 3'b111;

   state_t              state_r;
   logic [3:0]          opcode_r;
   ctrl_t               ctrl_r;
   logic                illegal_r;
   logic [RETIRE_W-1:0] retired_r;

   function automatic logic is_undefined(input logic [3:0] op);
      return (op >= 4'h7) && (op <= 4'hE);
   endfunction

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   // Outputs are registered, so they are computed for the state being entered.
   function automatic ctrl_t ctrl_for(input state_t st, input logic [3:0] op);
      ctrl_t c;
      c.mem_read     = 1'b0;
      c.mem_write    = 1'b0;
      c.alu_op       = ALU_PASS;
      c.memtoreg_sel = 1'b1;
      c.reg_write    = 1'b0;
      c.halted       = 1'b0;
      case (st)
         ST_FETCH: c.mem_read = 1'b1;
         ST_EXEC: begin
            case (op)
               OP_ADD, OP_LOAD, OP_STORE: c.alu_op = ALU_ADD;
               OP_SUB:                    c.alu_op = ALU_SUB;
               OP_AND:                    c.alu_op = ALU_AND;
               OP_OR:                     c.alu_op = ALU_OR;
               default:                   c.alu_op = ALU_PASS;
            endcase
         end
         ST_MEM: begin
            if (op == OP_LOAD) c.mem_read = 1'b1;
            else               c.mem_write = 1'b1;
         end
         ST_WB: begin
            c.reg_write    = 1'b1;
            c.memtoreg_sel = (op != OP_LOAD);
         end
         ST_HALT: c.halted = 1'b1;
         default: c.halted = 1'b0;
      endcase
      return c;
   endfunction

   // State sequencing, opcode latch, registered strobes, illegal flag and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         opcode_r  <= OP_NOP;
         ctrl_r    <= ctrl_for(ST_IDLE, OP_NOP);
         illegal_r <= 1'b0;
         retired_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  state_r <= ST_FETCH;
                  ctrl_r  <= ctrl_for(ST_FETCH, opcode_r);
               end
            end
            ST_FETCH: begin
               if (bus.mem_ready) begin
                  state_r <= ST_DECODE;
                  ctrl_r  <= ctrl_for(ST_DECODE, opcode_r);
               end
            end
            ST_DECODE: begin
               opcode_r <= bus.opcode;
               if (bus.opcode == OP_HALT) begin
                  state_r   <= ST_HALT;
                  ctrl_r    <= ctrl_for(ST_HALT, bus.opcode);
                  retired_r <= retired_r + RETIRE_W'(1'b1);
               end else if ((bus.opcode == OP_NOP) || is_undefined(bus.opcode)) begin
                  state_r   <= ST_FETCH;
                  ctrl_r    <= ctrl_for(ST_FETCH, bus.opcode);
                  retired_r <= retired_r + RETIRE_W'(1'b1);
                  illegal_r <= illegal_r | is_undefined(bus.opcode);
               end else begin
                  state_r <= ST_EXEC;
                  ctrl_r  <= ctrl_for(ST_EXEC, bus.opcode);
               end
            end
            ST_EXEC: begin
               if (is_mem_op(opcode_r)) begin
                  state_r <= ST_MEM;
                  ctrl_r  <= ctrl_for(ST_MEM, opcode_r);
               end else begin
                  state_r <= ST_WB;
                  ctrl_r  <= ctrl_for(ST_WB, opcode_r);
               end
            end
            ST_MEM: begin
               if (bus.mem_ready && (opcode_r == OP_LOAD)) begin
                  state_r <= ST_WB;
                  ctrl_r  <= ctrl_for(ST_WB, opcode_r);
               end else if (bus.mem_ready) begin
                  state_r   <= ST_FETCH;
                  ctrl_r    <= ctrl_for(ST_FETCH, opcode_r);
                  retired_r <= retired_r + RETIRE_W'(1'b1);
               end
            end
            ST_WB: begin
               state_r   <= ST_FETCH;
               ctrl_r    <= ctrl_for(ST_FETCH, opcode_r);
               retired_r <= retired_r + RETIRE_W'(1'b1);
            end
            ST_HALT: begin
               state_r <= ST_HALT;
               ctrl_r  <= ctrl_for(ST_HALT, opcode_r);
            end
            default: begin
               state_r <= ST_IDLE;
               ctrl_r  <= ctrl_for(ST_IDLE, opcode_r);
            end
         endcase
      end
   end

   // IR load and PC increment fire in the same cycle memory returns the instruction.
   assign bus.ir_write     = (state_r == ST_FETCH) && bus.mem_ready;
   assign bus.pc_write     = (state_r == ST_FETCH) && bus.mem_ready;
   assign bus.mem_read     = ctrl_r.mem_read;
   assign bus.mem_write    = ctrl_r.mem_write;
   assign bus.alu_op       = ctrl_r.alu_op;
   assign bus.memtoreg_sel = ctrl_r.memtoreg_sel;
   assign bus.reg_write    = ctrl_r.reg_write;
   assign bus.halted       = ctrl_r.halted;
   assign bus.illegal      = illegal_r;
   assign bus.retired      = retired_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: instruction classes, memory waits, illegal opcode,
// HALT, asynchronous reset abort and retire-counter wrap (4-bit counter).
module tb_cpu_ctrl_fsm;
   localparam int RW = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   cpu_ctrl_fsm_if #(.RETIRE_W(RW)) bus ();

   cpu_ctrl_fsm #(.RETIRE_W(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] alu_ops [4];
      logic [2:0] alu_exp [4];
      alu_ops = '{4'h1, 4'h2, 4'h3, 4'h4};
      alu_exp = '{3'b000, 3'b001, 3'b010, 3'b011};
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.mem_ready = 1'b1;
      bus.opcode = 4'h1;
      repeat (2) step();

      check_eq("rst_mem_read", 16'(bus.mem_read), 16'd0);
      check_eq("rst_mem_write", 16'(bus.mem_write), 16'd0);
      check_eq("rst_reg_write", 16'(bus.reg_write), 16'd0);
      check_eq("rst_ir_write", 16'(bus.ir_write), 16'd0);
      check_eq("rst_alu_op", 16'(bus.alu_op), 16'h7);
      check_eq("rst_memtoreg", 16'(bus.memtoreg_sel), 16'd1);
      check_eq("rst_halted", 16'(bus.halted), 16'd0);
      check_eq("rst_illegal", 16'(bus.illegal), 16'd0);
      check_eq("rst_retired", 16'(bus.retired), 16'd0);

      // ADD with memory always ready
      rst = 1'b0;
      bus.start = 1'b1;
      step();
      check_eq("add_c1_ir_write", 16'(bus.ir_write), 16'd1);
      check_eq("add_c1_pc_write", 16'(bus.pc_write), 16'd1);
      check_eq("add_c1_mem_read", 16'(bus.mem_read), 16'd1);
      bus.start = 1'b0;
      step();
      check_eq("add_c2_ir_write", 16'(bus.ir_write), 16'd0);
      check_eq("add_c2_mem_read", 16'(bus.mem_read), 16'd0);
      step();
      check_eq("add_c3_alu_op", 16'(bus.alu_op), 16'h0);
      check_eq("add_c3_reg_write", 16'(bus.reg_write), 16'd0);
      step();
      check_eq("add_c4_reg_write", 16'(bus.reg_write), 16'd1);
      check_eq("add_c4_memtoreg", 16'(bus.memtoreg_sel), 16'd1);
      check_eq("add_c4_alu_pass", 16'(bus.alu_op), 16'h7);
      step();
      check_eq("add_done_reg_write", 16'(bus.reg_write), 16'd0);
      check_eq("add_retired", 16'(bus.retired), 16'd1);

      // LOAD with three memory wait cycles in MEM
      bus.opcode = 4'h5;
      step();
      step();
      check_eq("load_exec_alu", 16'(bus.alu_op), 16'h0);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("load_mem_read", 16'(bus.mem_read), 16'd1);
         check_eq("load_mem_write", 16'(bus.mem_write), 16'd0);
      end
      bus.mem_ready = 1'b1;
      step();
      check_eq("load_wb_memtoreg", 16'(bus.memtoreg_sel), 16'd0);
      check_eq("load_wb_reg_write", 16'(bus.reg_write), 16'd1);
      check_eq("load_wb_mem_read", 16'(bus.mem_read), 16'd0);
      step();
      check_eq("load_done_reg_write", 16'(bus.reg_write), 16'd0);
      check_eq("load_done_memtoreg", 16'(bus.memtoreg_sel), 16'd1);
      check_eq("load_retired", 16'(bus.retired), 16'd2);

      // STORE
      bus.opcode = 4'h6;
      step();
      step();
      check_eq("store_exec_alu", 16'(bus.alu_op), 16'h0);
      step();
      check_eq("store_mem_write", 16'(bus.mem_write), 16'd1);
      check_eq("store_mem_read", 16'(bus.mem_read), 16'd0);
      check_eq("store_reg_write", 16'(bus.reg_write), 16'd0);
      step();
      check_eq("store_done_mem_write", 16'(bus.mem_write), 16'd0);
      check_eq("store_done_reg_write", 16'(bus.reg_write), 16'd0);
      check_eq("store_retired", 16'(bus.retired), 16'd3);

      // Undefined opcode 0x9
      bus.opcode = 4'h9;
      step();
      check_eq("ill_decode_flag", 16'(bus.illegal), 16'd0);
      step();
      check_eq("ill_flag_set", 16'(bus.illegal), 16'd1);
      check_eq("ill_reg_write", 16'(bus.reg_write), 16'd0);
      check_eq("ill_retired", 16'(bus.retired), 16'd4);
      check_eq("ill_next_fetch", 16'(bus.ir_write), 16'd1);

      // ALU opcode to alu_op mapping; illegal stays sticky
      for (int i = 0; i < 4; i++) begin
         bus.opcode = alu_ops[i];
         step();
         step();
         check_eq("alu_map", 16'(bus.alu_op), 16'(alu_exp[i]));
         step();
         check_eq("alu_wb_reg_write", 16'(bus.reg_write), 16'd1);
         step();
         check_eq("ill_sticky", 16'(bus.illegal), 16'd1);
      end
      check_eq("alu_retired", 16'(bus.retired), 16'd8);

      // Asynchronous reset during WB of ADD
      bus.opcode = 4'h1;
      step();
      step();
      step();
      check_eq("abort_wb_reg_write", 16'(bus.reg_write), 16'd1);
      rst = 1'b1;
      #1;
      check_eq("abort_reg_write", 16'(bus.reg_write), 16'd0);
      check_eq("abort_retired", 16'(bus.retired), 16'd0);
      check_eq("abort_illegal", 16'(bus.illegal), 16'd0);
      check_eq("abort_alu_op", 16'(bus.alu_op), 16'h7);
      step();
      rst = 1'b0;
      bus.start = 1'b1;
      bus.opcode = 4'h0;
      step();
      bus.start = 1'b0;

      // 16 NOPs wrap the 4-bit counter
      for (int i = 1; i <= 16; i++) begin
         step();
         step();
         if (i == 15) check_eq("nop_retired_15", 16'(bus.retired), 16'd15);
      end
      check_eq("nop_wrap", 16'(bus.retired), 16'd0);

      // HALT absorbs start and mem_ready
      bus.opcode = 4'hF;
      step();
      step();
      check_eq("halt_halted", 16'(bus.halted), 16'd1);
      check_eq("halt_retired", 16'(bus.retired), 16'd1);
      bus.start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.mem_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
         step();
         check_eq("halt_stays", 16'(bus.halted), 16'd1);
         check_eq("halt_mem_read", 16'(bus.mem_read), 16'd0);
         check_eq("halt_ir_write", 16'(bus.ir_write), 16'd0);
         check_eq("halt_retired_hold", 16'(bus.retired), 16'd1);
      end
      rst = 1'b1;
      #1;
      check_eq("halt_rst_halted", 16'(bus.halted), 16'd0);
      bus.start = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
      check_eq("idle_mem_read", 16'(bus.mem_read), 16'd0);
      check_eq("idle_halted", 16'(bus.halted), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
